// File: rtl/pqc_pkg.sv
// Shared decode constants, tracker entry type and decode helpers for the
// PQC forwarding/stall controller.
//   OPC_* / F3_* / F7_*   : opcode, funct3 and funct7 encodings that matter
//   trk_entry_t           : one in-flight register writer {valid, rd, is_load}
//   pqc_use_t             : implicit-register usage mask plus multi-cycle flag
//   pqc_usage()           : funct7 -> usage mask / multi-cycle flag
//   writer_decode()       : opcode/funct3/rd -> tracker entry
package pqc_pkg;

  localparam logic [6:0] OPC_PQC   = 7'b0001011;
  localparam logic [2:0] F3_PQC    = 3'b011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [2:0] F3_ADDI   = 3'b000;
  localparam logic [2:0] F3_SLLI   = 3'b001;

  // Single-cycle variants that only read the last implicit register
  localparam logic [6:0] F7_LAST_0 = 7'b0000000;
  localparam logic [6:0] F7_LAST_3 = 7'b0000011;
  localparam logic [6:0] F7_LAST_4 = 7'b0000100;
  // Multi-cycle variants that read every implicit register
  localparam logic [6:0] F7_MC_5   = 7'b0000101;
  localparam logic [6:0] F7_MC_6   = 7'b0000110;
  localparam logic [6:0] F7_MC_7   = 7'b0000111;

  // Upper bound on the implicit register count the usage mask can describe
  localparam int MAX_IMPL = 32;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } trk_entry_t;

  typedef struct packed {
    logic [MAX_IMPL-1:0] mask;
    logic                multi;
  } pqc_use_t;

  // Bit i of mask set means implicit register i is read by this funct7.
  function automatic pqc_use_t pqc_usage(input logic [6:0] f7, input int num_impl);
    pqc_use_t u;
    u = '0;
    case (f7)
      F7_LAST_0, F7_LAST_3, F7_LAST_4: u.mask = MAX_IMPL'(1) << (num_impl - 1);
      F7_MC_5, F7_MC_6, F7_MC_7: begin
        u.mask  = (MAX_IMPL'(1) << num_impl) - MAX_IMPL'(1);
        u.multi = 1'b1;
      end
      default: u = '0;
    endcase
    return u;
  endfunction

  // x0 is never a real destination, so it never produces a valid entry.
  function automatic trk_entry_t writer_decode(input logic [6:0] opc,
                                               input logic [2:0] f3,
                                               input logic [4:0] rd);
    trk_entry_t e;
    e.rd      = rd;
    e.is_load = (opc == OPC_LOAD);
    e.valid   = (rd != 5'd0) &&
                (e.is_load || ((opc == OPC_OPIMM) && ((f3 == F3_ADDI) || (f3 == F3_SLLI))));
    return e;
  endfunction

endpackage

// File: rtl/pqc_fwd_ctrl_if.sv
// ID-side bus between the core and the PQC forwarding/stall controller.
//   id_inst/id_valid : instruction in ID and its valid flag
//   pipe_adv         : ID moves to EX this cycle
//   flush            : kill ID and ID/EX
//   pqc_done         : multi-cycle PQC unit finished early
//   fwd_sel          : per-implicit-register forwarding select (SEL_W each)
//   stall_out        : hold IF/ID and insert a bubble
//   pqc_busy         : multi-cycle PQC unit occupied
// master = core side, slave = controller side.
interface pqc_fwd_ctrl_if #(
  parameter int NUM_IMPL = 3,
  parameter int SEL_W    = 2
);
  logic [31:0]               id_inst;
  logic                      id_valid;
  logic                      pipe_adv;
  logic                      flush;
  logic                      pqc_done;
  logic [NUM_IMPL*SEL_W-1:0] fwd_sel;
  logic                      stall_out;
  logic                      pqc_busy;

  modport master (
    output id_inst, id_valid, pipe_adv, flush, pqc_done,
    input  fwd_sel, stall_out, pqc_busy
  );

  modport slave (
    input  id_inst, id_valid, pipe_adv, flush, pqc_done,
    output fwd_sel, stall_out, pqc_busy
  );
endinterface

// File: rtl/pqc_wr_tracker.sv
// Shift-register scoreboard of in-flight register writers after ID.
//   clk, rst_n : clock, asynchronous active-low reset
//   adv_i      : pipeline advances; ins_i enters slot 0, older slots shift
//   flush_i    : invalidate slot 0 this cycle
//   ins_i      : entry for the instruction leaving ID (valid already gated)
//   ent_o      : slot k = stage k+1 after ID
module pqc_wr_tracker
  import pqc_pkg::*;
#(
  parameter int PIPE_DEPTH = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        adv_i,
  input  logic                        flush_i,
  input  trk_entry_t                  ins_i,
  output trk_entry_t [PIPE_DEPTH-1:0] ent_o
);

  trk_entry_t [PIPE_DEPTH-1:0] ent_q, ent_d;

  always_comb begin
    ent_d = ent_q;
    if (adv_i) begin
      for (int k = PIPE_DEPTH - 1; k >= 1; k--) ent_d[k] = ent_q[k-1];
      ent_d[0] = ins_i;
    end
    // A flush without an advance still kills the ID/EX slot in place.
    if (flush_i) ent_d[0].valid = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ent_q <= '0;
    else        ent_q <= ent_d;
  end

  assign ent_o = ent_q;

endmodule

// File: rtl/pqc_fwd_ctrl.sv
// Forwarding and stall controller for the PQC instruction class, which
// implicitly reads registers IMPL_BASE..IMPL_BASE+NUM_IMPL-1.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pqc_fwd_ctrl_if slave (ID instruction and pipeline control
//                in; fwd_sel, stall_out, pqc_busy out)
// Outputs are combinational from the tracker/busy counter and id_inst.
module pqc_fwd_ctrl
  import pqc_pkg::*;
#(
  parameter int NUM_IMPL   = 3,
  parameter int IMPL_BASE  = 29,
  parameter int PIPE_DEPTH = 3,
  parameter int MC_LATENCY = 8,
  parameter int SEL_W      = $clog2(PIPE_DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  pqc_fwd_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(MC_LATENCY + 1);

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd;

  assign opc = bus.id_inst[6:0];
  assign rd  = bus.id_inst[11:7];
  assign f3  = bus.id_inst[14:12];
  assign f7  = bus.id_inst[31:25];

  pqc_use_t            usage;
  logic                is_pqc;
  logic [NUM_IMPL-1:0] use_mask;

  assign usage    = pqc_usage(f7, NUM_IMPL);
  assign is_pqc   = bus.id_valid && (opc == OPC_PQC) && (f3 == F3_PQC);
  assign use_mask = is_pqc ? usage.mask[NUM_IMPL-1:0] : '0;

  // rs1/rs2 fields and mask bits beyond NUM_IMPL play no part here.
  logic unused_bits;
  assign unused_bits = ^{bus.id_inst[24:15], usage.mask};

  trk_entry_t [PIPE_DEPTH-1:0] ent;
  trk_entry_t                  ins;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        load_use, stall, leave_id, issue;
  logic [NUM_IMPL*SEL_W-1:0]   fwd_sel;

  // Youngest match wins: scan oldest to youngest so the last hit sticks.
  // A load still in EX cannot forward yet; that case stalls instead.
  always_comb begin
    fwd_sel  = '0;
    load_use = 1'b0;
    for (int i = 0; i < NUM_IMPL; i++) begin
      if (use_mask[i]) begin
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
          if (ent[k].valid && (ent[k].rd == 5'(IMPL_BASE + i)) &&
              !((k == 0) && ent[k].is_load))
            fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
        end
        if (ent[0].valid && ent[0].is_load && (ent[0].rd == 5'(IMPL_BASE + i)))
          load_use = 1'b1;
      end
    end
  end

  assign stall    = load_use || (is_pqc && (cnt_q != '0));
  assign leave_id = bus.id_valid && bus.pipe_adv && !stall && !bus.flush;
  assign issue    = leave_id && is_pqc && usage.multi;

  always_comb begin
    ins       = writer_decode(opc, f3, rd);
    ins.valid = ins.valid && leave_id;
  end

  pqc_wr_tracker #(
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv_i   (bus.pipe_adv),
    .flush_i (bus.flush),
    .ins_i   (ins),
    .ent_o   (ent)
  );

  // A new issue takes priority over an early-done pulse; flush leaves the
  // counter alone because the unit has already accepted the operation.
  always_comb begin
    cnt_d = cnt_q;
    if (issue)              cnt_d = CNT_W'(MC_LATENCY);
    else if (bus.pqc_done)  cnt_d = '0;
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.fwd_sel   = fwd_sel;
  assign bus.stall_out = stall;
  assign bus.pqc_busy  = (cnt_q != '0);

endmodule

// File: tb/tb_pqc_fwd_ctrl.sv
// Self-checking bench for pqc_fwd_ctrl: directed scenarios plus randomized
// instruction streams compared against an array-based reference model.
module tb_pqc_fwd_ctrl;

  localparam int NUM_IMPL   = 3;
  localparam int IMPL_BASE  = 29;
  localparam int PIPE_DEPTH = 3;
  localparam int MC_LATENCY = 8;
  localparam int SEL_W      = $clog2(PIPE_DEPTH + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pqc_fwd_ctrl_if #(.NUM_IMPL(NUM_IMPL), .SEL_W(SEL_W)) bus ();

  pqc_fwd_ctrl #(
    .NUM_IMPL   (NUM_IMPL),
    .IMPL_BASE  (IMPL_BASE),
    .PIPE_DEPTH (PIPE_DEPTH),
    .MC_LATENCY (MC_LATENCY),
    .SEL_W      (SEL_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] i_type(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {12'd1, 5'd0, f3, rd, opc};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd); return i_type(3'b000, rd, 7'b0010011); endfunction
  function automatic logic [31:0] ld(input logic [4:0] rd);   return i_type(3'b011, rd, 7'b0000011); endfunction
  function automatic logic [31:0] pqc(input logic [6:0] f7);
    return {f7, 5'd0, 5'd0, 3'b011, 5'd0, 7'b0001011};
  endfunction
  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- reference model ----------------
  bit m_vld [PIPE_DEPTH];
  int m_rd  [PIPE_DEPTH];
  bit m_ld  [PIPE_DEPTH];
  int m_cnt;

  logic [NUM_IMPL*SEL_W-1:0] e_fwd;
  bit e_stall, e_busy;

  logic [31:0] cur_inst;
  bit cur_v, cur_adv, cur_fl, cur_dn;

  function automatic bit is_pqc(input logic [31:0] inst, input bit v);
    return v && (inst[6:0] == 7'b0001011) && (inst[14:12] == 3'b011);
  endfunction

  // Set of implicit registers read, as a bitmask over 0..NUM_IMPL-1.
  function automatic int used_regs(input logic [31:0] inst, input bit v);
    int f7;
    if (!is_pqc(inst, v)) return 0;
    f7 = int'(inst[31:25]);
    if (f7 == 0 || f7 == 3 || f7 == 4) return 1 << (NUM_IMPL - 1);
    if (f7 >= 5 && f7 <= 7) return (1 << NUM_IMPL) - 1;
    return 0;
  endfunction

  function automatic bit is_multi(input logic [31:0] inst, input bit v);
    return is_pqc(inst, v) && (int'(inst[31:25]) >= 5) && (int'(inst[31:25]) <= 7);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < PIPE_DEPTH; k++) begin m_vld[k] = 0; m_rd[k] = 0; m_ld[k] = 0; end
    m_cnt = 0;
  endtask

  task automatic model_eval(input logic [31:0] inst, input bit v);
    int u;
    u = used_regs(inst, v);
    e_fwd = '0;
    e_stall = 0;
    for (int i = 0; i < NUM_IMPL; i++) begin
      if (u[i]) begin
        for (int k = 0; k < PIPE_DEPTH; k++) begin
          if (m_vld[k] && m_rd[k] == IMPL_BASE + i && !(k == 0 && m_ld[k])) begin
            e_fwd[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
            break;
          end
        end
        if (m_vld[0] && m_ld[0] && m_rd[0] == IMPL_BASE + i) e_stall = 1;
      end
    end
    if (is_pqc(inst, v) && m_cnt > 0) e_stall = 1;
    e_busy = (m_cnt > 0);
  endtask

  task automatic model_step();
    bit wr, isld, go;
    int rd;
    go   = cur_v && cur_adv && !e_stall && !cur_fl;
    isld = (cur_inst[6:0] == 7'b0000011);
    wr   = isld || (cur_inst[6:0] == 7'b0010011 && (cur_inst[14:12] == 3'b000 || cur_inst[14:12] == 3'b001));
    rd   = int'(cur_inst[11:7]);
    if (cur_adv) begin
      for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
        m_vld[k] = m_vld[k-1]; m_rd[k] = m_rd[k-1]; m_ld[k] = m_ld[k-1];
      end
      m_vld[0] = go && wr && rd != 0; m_rd[0] = rd; m_ld[0] = isld;
    end else if (cur_fl) begin
      m_vld[0] = 0;
    end
    if (go && is_multi(cur_inst, cur_v)) m_cnt = MC_LATENCY;
    else if (cur_dn)                     m_cnt = 0;
    else if (m_cnt > 0)                  m_cnt--;
  endtask

  // ---------------- drive / check helpers ----------------
  function automatic int sel_of(input int i);
    return int'((bus.fwd_sel >> (i * SEL_W)) & ((1 << SEL_W) - 1));
  endfunction

  // Called just after a falling edge: apply inputs, then compare.
  task automatic drive(input logic [31:0] inst, input bit v, input bit adv,
                       input bit fl, input bit dn, input string tag);
    bus.id_inst = inst; bus.id_valid = v; bus.pipe_adv = adv; bus.flush = fl; bus.pqc_done = dn;
    cur_inst = inst; cur_v = v; cur_adv = adv; cur_fl = fl; cur_dn = dn;
    #1;
    model_eval(inst, v);
    check_val({tag, " fwd_sel"},   bus.fwd_sel,   e_fwd);
    check_val({tag, " stall_out"}, bus.stall_out, e_stall);
    check_val({tag, " pqc_busy"},  bus.pqc_busy,  e_busy);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic go(input logic [31:0] inst, input string tag);
    drive(inst, 1, 1, 0, 0, tag);
    tick();
  endtask

  task automatic drain(input int n);
    repeat (n) go(NOP, "drain");
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [6:0] f7s [10] = '{7'd0, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd1, 7'd2, 7'd8, 7'h40};
    logic [4:0] rds [5]  = '{5'd0, 5'd29, 5'd30, 5'd31, 5'd7};
    logic [4:0] rd;
    rd = rds[$urandom_range(0, 4)];
    case ($urandom_range(0, 8))
      0:       return addi(rd);
      1:       return i_type(3'b001, rd, 7'b0010011);
      2:       return ld(rd);
      3, 4:    return pqc(f7s[$urandom_range(0, 9)]);
      5:       return {7'd0, 5'd1, 5'd2, 3'b000, rd, 7'b0110011};
      6:       return i_type(3'b010, rd, 7'b0010011);
      7:       return {f7s[$urandom_range(0, 9)], 10'd0, 3'b010, 5'd0, 7'b0001011};
      default: return NOP;
    endcase
  endfunction

  initial begin
    model_reset();
    bus.id_inst = pqc(7'd7); bus.id_valid = 1; bus.pipe_adv = 1; bus.flush = 0; bus.pqc_done = 0;
    #1 rst_n = 1'b0;
    #2;
    check_val("reset fwd_sel",   bus.fwd_sel,   0);
    check_val("reset stall_out", bus.stall_out, 0);
    check_val("reset pqc_busy",  bus.pqc_busy,  0);
    @(negedge clk);
    rst_n = 1'b1;

    // Forward distance of an addi x31 as NOPs are placed in between
    for (int gap = 0; gap < 4; gap++) begin
      go(addi(5'd31), "dist addi");
      drain(gap);
      drive(pqc(7'd0), 1, 1, 0, 0, "dist pqc");
      check_val($sformatf("dist%0d x31 sel", gap), sel_of(2), (gap < 3) ? gap + 1 : 0);
      tick();
      drain(3);
    end

    // Youngest of two writers wins; funct7=0 does not read x29
    go(addi(5'd29), "yw addi a");
    go(addi(5'd29), "yw addi b");
    drive(pqc(7'd7), 1, 1, 0, 0, "yw pqc7");
    check_val("youngest x29 sel", sel_of(0), 1);
    tick();
    drain(10);
    go(addi(5'd29), "yw0 addi a");
    go(addi(5'd29), "yw0 addi b");
    drive(pqc(7'd0), 1, 1, 0, 0, "yw0 pqc0");
    check_val("f7=0 x29 sel", sel_of(0), 0);
    tick();
    drain(3);

    // Load-use on x30: one stall cycle, then forward from stage 2
    go(ld(5'd30), "lu ld");
    drive(pqc(7'd6), 1, 1, 0, 0, "lu pqc a");
    check_val("load-use stall", bus.stall_out, 1);
    tick();
    drive(pqc(7'd6), 1, 1, 0, 0, "lu pqc b");
    check_val("load-use released", bus.stall_out, 0);
    check_val("load-use x30 sel", sel_of(1), 2);
    tick();
    drain(10);

    // Multi-cycle busy for the full latency
    go(pqc(7'd5), "mc issue");
    for (int c = 0; c < MC_LATENCY; c++) begin
      drive(pqc(7'd0), 1, 1, 0, 0, "mc wait");
      check_val($sformatf("mc busy c%0d", c), bus.pqc_busy, 1);
      check_val($sformatf("mc stall c%0d", c), bus.stall_out, 1);
      tick();
    end
    drive(pqc(7'd0), 1, 1, 0, 0, "mc after");
    check_val("mc busy end", bus.pqc_busy, 0);
    tick();

    // Early completion on the third busy cycle
    go(pqc(7'd5), "done issue");
    for (int c = 0; c < 3; c++) begin
      drive(pqc(7'd0), 1, 1, 0, (c == 2), "done wait");
      check_val($sformatf("done busy c%0d", c), bus.pqc_busy, 1);
      tick();
    end
    drive(pqc(7'd0), 1, 1, 0, 0, "done after");
    check_val("done busy cleared", bus.pqc_busy, 0);
    check_val("done stall cleared", bus.stall_out, 0);
    tick();
    drain(2);

    // Flushed writer is not tracked
    drive(addi(5'd31), 1, 1, 1, 0, "flush addi");
    tick();
    drive(pqc(7'd0), 1, 1, 0, 0, "flush pqc");
    check_val("flush x31 sel", sel_of(2), 0);
    tick();
    drain(3);

    // Asynchronous reset while busy with a live tracker entry
    go(pqc(7'd5), "ar issue");
    go(addi(5'd31), "ar addi");
    drive(pqc(7'd0), 1, 1, 0, 0, "ar pqc");
    check_val("ar pre x31 sel", sel_of(2), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("ar fwd_sel",   bus.fwd_sel,   0);
    check_val("ar stall_out", bus.stall_out, 0);
    check_val("ar pqc_busy",  bus.pqc_busy,  0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(pqc(7'd0), 1, 1, 0, 0, "ar post");
    check_val("ar post x31 sel", sel_of(2), 0);
    check_val("ar post busy", bus.pqc_busy, 0);
    tick();

    // Randomized streams
    for (int n = 0; n < 1500; n++) begin
      drive(rnd_inst(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 11) == 0), ($urandom_range(0, 19) == 0), "rand");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
